// File: rtl/te_itype_detector.sv
// te_itype_detector
// Combinational E-Trace itype classifier for the CVA6 trace-encoder connector.
// Looks at the current retired instruction (cc_*) and the address of the next
// one (nc_*) to decide whether the current instruction is a trap, a trap
// return, a resolved branch or an uninferable jump. No state is held; clk_i
// and rst_ni exist only to match the connector's port list.

module te_itype_detector #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            pc_valid_i,
   input  logic            cc_valid_i,
   input  logic            nc_valid_i,
   input  logic [XLEN-1:0] pc_iaddr_i,
   input  logic [XLEN-1:0] cc_iaddr_i,
   input  logic [XLEN-1:0] nc_iaddr_i,
   input  logic [XLEN-1:0] cc_inst_data_i,
   input  logic            cc_compressed_i,
   input  logic            cc_exception_i,
   input  logic            cc_interrupt_i,
   input  logic            cc_eret_i,
   output logic [2:0]      itype_o
);

   typedef enum logic [2:0] {
      ITYPE_NONE       = 3'd0,
      ITYPE_EXCEPTION  = 3'd1,
      ITYPE_INTERRUPT  = 3'd2,
      ITYPE_ERET       = 3'd3,
      ITYPE_NT_BRANCH  = 3'd4,
      ITYPE_TK_BRANCH  = 3'd5,
      ITYPE_UNINF_JUMP = 3'd6
   } itype_e;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Compressed-instruction fields (only bits [15:0] matter for RVC).
   logic [1:0] c_op;
   logic [2:0] c_funct3;
   logic       c_bit12;
   logic [4:0] c_rs1;
   logic [4:0] c_rs2;

   assign c_op     = cc_inst_data_i[1:0];
   assign c_funct3 = cc_inst_data_i[15:13];
   assign c_bit12  = cc_inst_data_i[12];
   assign c_rs1    = cc_inst_data_i[11:7];
   assign c_rs2    = cc_inst_data_i[6:2];

   // Pure-decode results for the current instruction.
   logic is_branch;
   logic is_uninf_jump;

   // Decode branch / uninferable-jump from the current encoding.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      is_branch     = 1'b0;
      is_uninf_jump = 1'b0;
      if (cc_compressed_i) begin
         // C.BEQZ / C.BNEZ
         is_branch     = (c_op == 2'b01) && ((c_funct3 == 3'b110) || (c_funct3 == 3'b111));
         // C.JR (bit12=0) and C.JALR (bit12=1); rs1=0 or rs2!=0 are other ops.
         // c_bit12 selects between the two jump flavours, both uninferable.
         is_uninf_jump = (c_op == 2'b10) && (c_funct3 == 3'b100) &&
                         (c_rs1 != 5'd0) && (c_rs2 == 5'd0) && (c_bit12 || !c_bit12);
      end else begin
         is_branch     = (cc_inst_data_i[6:0] == OPC_BRANCH);
         is_uninf_jump = (cc_inst_data_i[6:0] == OPC_JALR);
      end
   end

   // Sequential successor address; wraps modulo 2^XLEN, so an instruction at
   // the top of the address space falls through to address zero.
   logic [XLEN-1:0] inst_len;
   logic [XLEN-1:0] seq_addr;
   logic            branch_fell_through;

   assign inst_len            = cc_compressed_i ? XLEN'(2) : XLEN'(4);
   assign seq_addr            = cc_iaddr_i + inst_len;
   assign branch_fell_through = (nc_iaddr_i == seq_addr);

   itype_e itype;

   // Priority classification: validity, interrupt, exception, eret, branch, jump.
   always_comb begin
      itype = ITYPE_NONE;
      if (!cc_valid_i) begin
         itype = ITYPE_NONE;
      end else if (cc_interrupt_i) begin
         itype = ITYPE_INTERRUPT;
      end else if (cc_exception_i) begin
         itype = ITYPE_EXCEPTION;
      end else if (cc_eret_i) begin
         itype = ITYPE_ERET;
      end else if (is_branch) begin
         // Without a valid next slot the branch outcome cannot be resolved.
         if (!nc_valid_i) begin
            itype = ITYPE_NONE;
         end else if (branch_fell_through) begin
            itype = ITYPE_NT_BRANCH;
         end else begin
            itype = ITYPE_TK_BRANCH;
         end
      end else if (is_uninf_jump) begin
         itype = ITYPE_UNINF_JUMP;
      end
   end

   assign itype_o = itype;

   // Inputs that are part of the connector interface but do not influence the
   // classification; reduced into a sink so they remain visibly intentional.
   logic unused_inputs;
   assign unused_inputs = ^{clk_i, rst_ni, pc_valid_i, pc_iaddr_i,
                            cc_inst_data_i[XLEN-1:16]};

endmodule

// File: tb/tb_te_itype_detector.sv
// Directed testbench for te_itype_detector: hand-computed itype expectations
// for branches, jumps, traps, invalid slots, address wrap and reset pulses.

module tb_te_itype_detector;

   localparam int unsigned XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic            pc_valid;
   logic            cc_valid;
   logic            nc_valid;
   logic [XLEN-1:0] pc_iaddr;
   logic [XLEN-1:0] cc_iaddr;
   logic [XLEN-1:0] nc_iaddr;
   logic [XLEN-1:0] cc_inst_data;
   logic            cc_compressed;
   logic            cc_exception;
   logic            cc_interrupt;
   logic            cc_eret;
   logic [2:0]      itype;

   int checks = 0;
   int passes = 0;

   te_itype_detector #(.XLEN(XLEN)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .pc_valid_i      (pc_valid),
      .cc_valid_i      (cc_valid),
      .nc_valid_i      (nc_valid),
      .pc_iaddr_i      (pc_iaddr),
      .cc_iaddr_i      (cc_iaddr),
      .nc_iaddr_i      (nc_iaddr),
      .cc_inst_data_i  (cc_inst_data),
      .cc_compressed_i (cc_compressed),
      .cc_exception_i  (cc_exception),
      .cc_interrupt_i  (cc_interrupt),
      .cc_eret_i       (cc_eret),
      .itype_o         (itype)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Let inputs settle, then sample away from the clock edge.
   task automatic check(input string tag, input logic [2:0] expected);
      @(posedge clk);
      #1;
      checks++;
      assert (itype === expected) passes++;
      else $error("FAIL %s: itype_o=%0d expected=%0d", tag, itype, expected);
   endtask

   // Baseline: valid current/next slots, BEQ at 0x8000_0000, no trap flags.
   task automatic set_defaults();
      pc_valid      = 1'b1;
      pc_iaddr      = 32'h7FFF_FFFC;
      cc_valid      = 1'b1;
      nc_valid      = 1'b1;
      cc_iaddr      = 32'h8000_0000;
      nc_iaddr      = 32'h8000_0008;
      cc_inst_data  = 32'h00B5_0463;
      cc_compressed = 1'b0;
      cc_exception  = 1'b0;
      cc_interrupt  = 1'b0;
      cc_eret       = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      set_defaults();
      // Output follows inputs even while reset is asserted.
      check("reset_taken_branch", 3'd5);
      rst_n = 1'b1;

      // 32-bit branch outcomes.
      check("beq_taken", 3'd5);
      nc_iaddr = 32'h8000_0004;
      check("beq_not_taken", 3'd4);
      nc_valid = 1'b0;
      check("beq_nc_invalid", 3'd0);

      // Compressed branch.
      set_defaults();
      cc_compressed = 1'b1;
      cc_inst_data  = 32'h0000_C119;
      cc_iaddr      = 32'h0000_0100;
      nc_iaddr      = 32'h0000_0102;
      check("cbeqz_not_taken", 3'd4);
      nc_iaddr = 32'h0000_0110;
      check("cbeqz_taken", 3'd5);
      nc_iaddr = 32'h0000_0104;
      check("cbeqz_plus4_taken", 3'd5);
      cc_inst_data = 32'h0000_E119; // C.BNEZ
      nc_iaddr     = 32'h0000_0102;
      check("cbnez_not_taken", 3'd4);
      cc_inst_data = 32'hFFFF_C119; // upper bits must be ignored
      nc_iaddr     = 32'h0000_0110;
      check("cbeqz_upper_ignored", 3'd5);

      // Jumps.
      set_defaults();
      cc_inst_data = 32'h0000_80E7;
      check("jalr", 3'd6);
      cc_inst_data = 32'h0080_006F;
      check("jal", 3'd0);
      cc_compressed = 1'b1;
      cc_inst_data  = 32'h0000_8082;
      check("c_jr", 3'd6);
      cc_inst_data = 32'h0000_9082; // C.JALR ra
      check("c_jalr", 3'd6);
      cc_inst_data = 32'h0000_9002;
      check("c_ebreak", 3'd0);
      cc_inst_data = 32'h0000_8086; // C.MV ra,ra
      check("c_mv", 3'd0);
      cc_inst_data = 32'h0000_A001; // C.J
      check("c_j", 3'd0);

      // Traps on a BEQ.
      set_defaults();
      cc_exception = 1'b1;
      check("exception", 3'd1);
      cc_interrupt = 1'b1;
      check("exc_and_irq", 3'd2);
      cc_exception = 1'b0;
      check("irq_only", 3'd2);
      cc_interrupt = 1'b0;
      cc_eret      = 1'b1;
      check("eret", 3'd3);
      cc_exception = 1'b1;
      check("eret_with_exc", 3'd1);

      // Invalid current slot overrides everything.
      set_defaults();
      cc_valid     = 1'b0;
      cc_exception = 1'b1;
      check("cc_invalid", 3'd0);
      cc_valid     = 1'b1;
      cc_exception = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pc_valid = 1'($urandom);
         pc_iaddr = $urandom;
         check("pc_ignored", 3'd5);
      end

      // Address wrap counts as sequential; reset pulse has no effect.
      set_defaults();
      cc_iaddr = 32'hFFFF_FFFC;
      nc_iaddr = 32'h0000_0000;
      check("wrap_not_taken", 3'd4);
      rst_n = 1'b0;
      check("wrap_in_reset", 3'd4);
      nc_iaddr = 32'h0000_0010;
      check("taken_in_reset", 3'd5);
      rst_n = 1'b1;
      cc_compressed = 1'b1;
      cc_inst_data  = 32'h0000_C119;
      cc_iaddr      = 32'hFFFF_FFFE;
      nc_iaddr      = 32'h0000_0000;
      check("cwrap_not_taken", 3'd4);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/te_itype_detector.md
Name: te_itype_detector

Overview:
- Combinational instruction-type classifier for the CVA6 trace-encoder connector.
- Takes three consecutive retired-instruction slots (previous pc_, current cc_, next nc_) plus the current instruction's trap flags and encoding.
- Produces the E-Trace itype code (3-bit itype width) of the current instruction for the downstream trace encoder.

Parameters:
- XLEN, 32, width of instruction addresses and of the instruction-data bus.

Ports:
- clk_i  in  1  clock; no state is clocked by it.
- rst_ni  in  1  reset, asynchronous, active-low; no state is reset by it.
- pc_valid_i  in  1  previous slot valid; not used by the classification.
- cc_valid_i  in  1  current slot valid.
- nc_valid_i  in  1  next slot valid.
- pc_iaddr_i  in  XLEN  previous instruction address; not used by the classification.
- cc_iaddr_i  in  XLEN  current instruction address.
- nc_iaddr_i  in  XLEN  next instruction address.
- cc_inst_data_i  in  XLEN  current instruction encoding; a compressed instruction sits in bits [15:0].
- cc_compressed_i  in  1  current instruction is 16-bit.
- cc_exception_i  in  1  current instruction trapped.
- cc_interrupt_i  in  1  trap is an interrupt.
- cc_eret_i  in  1  current instruction is an exception return (mret/sret/uret).
- itype_o  out  3  itype_e code.

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low (clk_i, rst_ni).
- The block is purely combinational and holds no state.
- itype_o settles in the same cycle as its inputs, with zero-cycle latency.
- Reset does not force itype_o; it reflects the inputs during and after reset.

Encoding (itype_e):
- 0: none
- 1: exception
- 2: interrupt
- 3: exception return
- 4: nontaken branch
- 5: taken branch
- 6: uninferable jump
- 7: reserved, never driven

Priority (first match wins):
1. cc_valid_i=0 -> 0.
2. cc_interrupt_i=1 -> 2, regardless of cc_exception_i.
3. cc_exception_i=1 -> 1.
4. cc_eret_i=1 -> 3.
5. Current instruction is a branch:
   - nc_valid_i=0 -> 0 (outcome unresolvable).
   - nc_iaddr_i == cc_iaddr_i + (cc_compressed_i ? 2 : 4) -> 4.
   - Otherwise -> 5.
   - The addition is modulo 2^XLEN; an address wrap at all-ones counts as sequential.
6. Current instruction is an uninferable jump -> 6.
7. Otherwise -> 0.

Decode when cc_compressed_i=0 (32-bit instruction):
- Branch: inst[6:0]=1100011.
- Uninferable jump: inst[6:0]=1100111 (JALR).
- JAL is inferable and yields 0.

Decode when cc_compressed_i=1 (bits [15:0] only; upper bits ignored):
- Branch: op[1:0]=01 with funct3[15:13]=110 (C.BEQZ) or 111 (C.BNEZ).
- Uninferable jump: op=10, inst[15:13]=100, inst[11:7]!=0, inst[6:2]=0. This covers C.JR (inst[12]=0) and C.JALR (inst[12]=1).
- C.J and C.JAL are inferable and yield 0.
- C.EBREAK and C.MV/C.ADD are not jumps.

Other rules:
- pc_valid_i and pc_iaddr_i have no effect on itype_o.
- cc_eret_i is trusted as given; the block does not decode MRET/SRET itself.

Test Plan:
1. Taken branch: cc_valid=1, nc_valid=1, cc_iaddr=0x8000_0000, inst=0x00B50463 (BEQ), nc_iaddr=0x8000_0008 -> itype_o=5. Same with nc_iaddr=0x8000_0004 -> 4. Same with nc_valid=0 -> 0.
2. Compressed branch: cc_compressed=1, inst=0x0000C119 (C.BEQZ), cc_iaddr=0x100:
   - nc_iaddr=0x102 -> 4.
   - nc_iaddr=0x110 -> 5.
   - The 32-bit increment (nc=0x104) -> 5.
3. Jumps:
   - inst=0x000080E7 (JALR ra) -> 6.
   - inst=0x0080006F (JAL) -> 0.
   - Compressed 0x00008082 (C.JR ra) -> 6.
   - Compressed 0x00009002 (C.EBREAK) -> 0.
4. Traps: BEQ instruction with:
   - cc_exception=1 -> 1.
   - cc_exception=1 and cc_interrupt=1 -> 2.
   - cc_interrupt=1 alone -> 2.
   - cc_eret=1 with exception=0 -> 3.
   - cc_eret=1 with exception=1 -> 1.
5. Invalid slot: cc_valid=0 with cc_exception=1 and a taken-branch setup -> 0. Toggle pc_valid/pc_iaddr randomly -> itype_o unchanged.
6. Wrap-around: cc_iaddr=0xFFFF_FFFC, BEQ, nc_iaddr=0x0000_0000 -> 4. Also pulse rst_ni low mid-test -> itype_o still follows the inputs combinationally.
